// File: rtl/line_feed_scheduler.sv
// line_feed_scheduler: streams one grayscale frame into image_processor line by line.
// The processor's line buffers are primed first. After that, one line is sent for each
// line-buffer-free interrupt. The frame ends with all-zero pad lines so the last image
// rows still get filtered.
module line_feed_scheduler #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              i_proc_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_intr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int PIX_W       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int TOTAL_LINES = IMG_H + PAD_LINES;
    localparam int LINE_W      = $clog2(TOTAL_LINES + 1);
    localparam int PRIME_EFF   = (IMG_H < PRIME_LINES) ? IMG_H : PRIME_LINES;
    localparam bit PRIME_ALL   = (IMG_H <= PRIME_LINES);

    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_W - 1);
    localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_EFF - 1);
    localparam logic [LINE_W-1:0] IMG_LAST   = LINE_W'(IMG_H - 1);
    localparam logic [LINE_W-1:0] PAD_LAST   = LINE_W'(TOTAL_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_LINE     = 3'd3,
        ST_PAD_WAIT = 3'd4,
        ST_PAD      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [PIX_W-1:0]   pix_cnt_r;
    logic [LINE_W-1:0]  line_cnt_r;
    logic [1:0]         credit_r;
    logic               intr_q_r;

    logic               feed_s;
    logic               beat_s;
    logic               consume_s;
    logic               last_pix_s;
    logic               start_s;
    logic               edge_s;
    logic               credit_ok_s;

    // A start is honoured only from IDLE, and interrupt edges only count during a frame.
    assign start_s     = i_start && (state_r == ST_IDLE);
    assign edge_s      = i_intr && !intr_q_r && (state_r != ST_IDLE);
    assign credit_ok_s = (credit_r != 2'd0);
    assign last_pix_s  = beat_s && (pix_cnt_r == PIX_LAST);

    // State register.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a line ends on its last beat, and the next line needs a credit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_next_s = ST_PRIME;
                else         state_next_s = ST_IDLE;
            end
            ST_PRIME: begin
                if (last_pix_s && (line_cnt_r == PRIME_LAST))
                    state_next_s = PRIME_ALL ? ST_PAD_WAIT : ST_WAIT;
                else
                    state_next_s = ST_PRIME;
            end
            ST_WAIT: begin
                if (credit_ok_s) state_next_s = ST_LINE;
                else             state_next_s = ST_WAIT;
            end
            ST_LINE: begin
                if (last_pix_s) state_next_s = (line_cnt_r == IMG_LAST) ? ST_PAD_WAIT : ST_WAIT;
                else            state_next_s = ST_LINE;
            end
            ST_PAD_WAIT: begin
                if (credit_ok_s) state_next_s = ST_PAD;
                else             state_next_s = ST_PAD_WAIT;
            end
            ST_PAD: begin
                if (last_pix_s) state_next_s = (line_cnt_r == PAD_LAST) ? ST_DONE : ST_PAD_WAIT;
                else            state_next_s = ST_PAD;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state decode: upstream handshake, beat qualification and credit consumption.
    always_comb begin
        feed_s    = 1'b0;
        beat_s    = 1'b0;
        consume_s = 1'b0;
        s_ready   = 1'b0;
        case (state_r)
            ST_PRIME, ST_LINE: begin
                feed_s  = 1'b1;
                s_ready = i_proc_ready;
                beat_s  = s_valid && i_proc_ready;
            end
            ST_PAD: begin
                beat_s = i_proc_ready;
            end
            ST_WAIT, ST_PAD_WAIT: begin
                consume_s = credit_ok_s;
            end
            default: begin
                feed_s    = 1'b0;
                beat_s    = 1'b0;
                consume_s = 1'b0;
                s_ready   = 1'b0;
            end
        endcase
    end

    // Pixel and line position; holds across bubbles, restarts on an accepted start.
    always_ff @(posedge axi_clk) begin
        if (axi_reset || start_s) begin
            pix_cnt_r  <= {PIX_W{1'b0}};
            line_cnt_r <= {LINE_W{1'b0}};
        end else if (last_pix_s) begin
            pix_cnt_r  <= {PIX_W{1'b0}};
            line_cnt_r <= line_cnt_r + LINE_W'(1);
        end else if (beat_s) begin
            pix_cnt_r  <= pix_cnt_r + PIX_W'(1);
        end else begin
            pix_cnt_r  <= pix_cnt_r;
        end
    end

    // Interrupt edge detect and the saturating line-buffer credit with sticky overrun.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            intr_q_r  <= 1'b0;
            credit_r  <= 2'd0;
            o_overrun <= 1'b0;
        end else begin
            intr_q_r <= i_intr;
            if (start_s) begin
                credit_r  <= 2'd0;
                o_overrun <= 1'b0;
            end else if (edge_s && !consume_s) begin
                if (credit_r == 2'd3) o_overrun <= 1'b1;
                else                  credit_r  <= credit_r + 2'd1;
            end else if (consume_s && !edge_s) begin
                credit_r <= credit_r - 2'd1;
            end else begin
                credit_r <= credit_r;
            end
        end
    end

    // Registered outputs: one-cycle pixel latency, busy mirrors state, done follows DONE.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            o_data       <= {DATA_W{1'b0}};
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_data       <= (feed_s && beat_s) ? s_data : {DATA_W{1'b0}};
            o_data_valid <= beat_s;
            o_busy       <= (state_next_s != ST_IDLE);
            o_done       <= (state_r == ST_DONE);
        end
    end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Bench for line_feed_scheduler: a scenario table drives whole frames. A transaction-level
// model checks each frame: the pixel stream, credit-limited line starts, pad zeros,
// done/busy timing and sticky overrun.
module tb_line_feed_scheduler;

    localparam int DW         = 8;
    localparam int W          = 8;
    localparam int H          = 6;
    localparam int PL         = 4;
    localparam int PD         = 2;
    localparam int IMG_BEATS  = W * H;
    localparam int ALL_BEATS  = W * (H + PD);
    localparam int NEED_CRED  = H + PD - PL;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic          i_start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          i_proc_ready;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          i_intr;
    logic          o_busy;
    logic          o_done;
    logic          o_overrun;

    always #5 clk = ~clk;

    line_feed_scheduler #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .PRIME_LINES(PL), .PAD_LINES(PD)
    ) dut (
        .axi_clk(clk), .axi_reset(axi_reset), .i_start(i_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .i_proc_ready(i_proc_ready), .o_data(o_data), .o_data_valid(o_data_valid),
        .i_intr(i_intr), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    typedef struct {
        string name;
        bit    toggle_valid;
        bit    random_mode;
        int    prime_edges;
        bit    coincident;
        int    abort_at;
        bit    exp_overrun;
        int    exp_beats;
    } scen_t;

    scen_t         scen[10];
    int            total = 0;
    int            bad   = 0;
    string         cur_name;
    bit            prev_overrun;
    logic [DW-1:0] acc_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s actual=%0d required=%0d", cur_name, name, act, exp);
        end
    endtask

    task automatic run_frame(input scen_t sc);
        int  in_count, out_count, granted, done_count, cyc, post_done, prime_left;
        int  started_beyond, exp_data;
        bit  in_beat, prev_in_beat, last_was_final, finished, start_pulsed;
        cur_name       = sc.name;
        acc_q.delete();
        in_count       = 0;
        out_count      = 0;
        granted        = 0;
        done_count     = 0;
        post_done      = 0;
        prev_in_beat   = 1'b0;
        last_was_final = 1'b0;
        finished       = 1'b0;
        start_pulsed   = 1'b0;
        prime_left     = sc.prime_edges;

        @(negedge clk);
        chk("idle_overrun", int'(o_overrun), int'(prev_overrun));
        chk("idle_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        i_start      = 1'b1;
        s_valid      = 1'b1;
        i_proc_ready = 1'b1;
        s_data       = DW'($urandom);
        @(posedge clk); #1;
        i_start = 1'b0;

        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("overrun_cleared", int'(o_overrun), 0);

            if (out_count < IMG_BEATS) chk("valid_follows_beat", int'(o_data_valid), int'(prev_in_beat));
            if (o_data_valid) begin
                exp_data = (out_count < IMG_BEATS && out_count < acc_q.size()) ? int'(acc_q[out_count]) : 0;
                chk("data", int'(o_data), exp_data);
                chk("line_without_credit", int'(out_count / W >= PL + granted), 0);
                if (out_count == ALL_BEATS - 1) chk("busy_last_beat", int'(o_busy), 1);
                out_count++;
            end

            if (o_done) begin
                done_count++;
                chk("done_after_last", int'(last_was_final), 1);
                chk("busy_at_done", int'(o_busy), 0);
                chk("done_beats", out_count, ALL_BEATS);
            end
            last_was_final = o_data_valid && (out_count == ALL_BEATS);

            if (o_busy && in_count < PL * W)
                chk("ready_prime", int'(s_ready), int'(i_proc_ready));
            else if (o_busy && in_count < IMG_BEATS && (in_count % W) != 0)
                chk("ready_midline", int'(s_ready), int'(i_proc_ready));
            else if (in_count >= IMG_BEATS)
                chk("ready_pad", int'(s_ready), 0);
            else if (in_count / W >= PL + granted)
                chk("ready_nocredit", int'(s_ready), 0);

            in_beat      = s_valid && s_ready;
            prev_in_beat = in_beat;
            if (done_count > 0) begin
                post_done++;
                if (post_done == 3) finished = 1'b1;
            end

            @(posedge clk); #1;
            if (in_beat) begin
                acc_q.push_back(s_data);
                in_count++;
            end

            if (sc.abort_at > 0 && in_count == sc.abort_at) begin
                axi_reset = 1'b1;
                i_intr    = 1'b0;
                @(posedge clk); #1;
                axi_reset = 1'b0;
                @(negedge clk);
                chk("abort_valid", int'(o_data_valid), 0);
                chk("abort_busy", int'(o_busy), 0);
                chk("abort_ready", int'(s_ready), 0);
                prev_overrun = 1'b0;
                return;
            end

            i_start = 1'b0;
            if (in_count == 10 && !start_pulsed) begin
                i_start      = 1'b1;
                start_pulsed = 1'b1;
            end

            started_beyond = (out_count + W - 1) / W - PL;
            if (started_beyond < 0) started_beyond = 0;
            if (i_intr) begin
                i_intr = 1'b0;
            end else if (prime_left > 0 && o_busy) begin
                i_intr = 1'b1;
                prime_left--;
                if (granted < 3) granted++;
            end else if (sc.coincident && in_beat && in_count == PL * W) begin
                i_intr = 1'b1;
                granted++;
            end else if (sc.random_mode) begin
                if (o_busy && granted < NEED_CRED && granted - started_beyond <= 2 &&
                    $urandom_range(0, 3) == 0) begin
                    i_intr = 1'b1;
                    granted++;
                end
            end else if (o_busy && out_count >= PL * W && out_count < ALL_BEATS &&
                         (out_count % W) == 0 && out_count / W >= PL + granted) begin
                i_intr = 1'b1;
                granted++;
            end

            s_data = DW'($urandom);
            if (sc.random_mode) begin
                s_valid      = ($urandom_range(0, 3) != 0);
                i_proc_ready = ($urandom_range(0, 3) != 0);
            end else begin
                s_valid      = sc.toggle_valid ? ~s_valid : 1'b1;
                i_proc_ready = 1'b1;
            end
        end

        chk("frame_finished", int'(finished), 1);
        chk("beats_total", out_count, sc.exp_beats);
        chk("inputs_total", in_count, IMG_BEATS);
        chk("done_count", done_count, 1);
        chk("overrun_end", int'(o_overrun), int'(sc.exp_overrun));
        prev_overrun = sc.exp_overrun;
        i_intr  = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        scen[0] = '{"basic",       1'b0, 1'b0, 0, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[1] = '{"toggle",      1'b1, 1'b0, 0, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[2] = '{"prime2",      1'b0, 1'b0, 2, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[3] = '{"prime4",      1'b0, 1'b0, 4, 1'b0, 0,  1'b1, ALL_BEATS};
        scen[4] = '{"coincident",  1'b0, 1'b0, 1, 1'b1, 0,  1'b0, ALL_BEATS};
        scen[5] = '{"abort",       1'b0, 1'b0, 0, 1'b0, 35, 1'b0, ALL_BEATS};
        scen[6] = '{"replay",      1'b0, 1'b0, 0, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[7] = '{"random_a",    1'b0, 1'b1, 0, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[8] = '{"random_b",    1'b0, 1'b1, 0, 1'b0, 0,  1'b0, ALL_BEATS};
        scen[9] = '{"random_c",    1'b0, 1'b1, 0, 1'b0, 0,  1'b0, ALL_BEATS};

        cur_name     = "reset";
        prev_overrun = 1'b0;
        axi_reset    = 1'b1;
        i_start      = 1'b0;
        s_data       = '0;
        s_valid      = 1'b1;
        i_proc_ready = 1'b1;
        i_intr       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(o_data), 0);
        chk("rst_valid", int'(o_data_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_ready", int'(s_ready), 0);
        @(posedge clk); #1;
        axi_reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_frame(scen[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_feed_scheduler.md
Name: line_feed_scheduler

Overview:
- Hardware sequencer that streams one grayscale frame into image_processor, line by line.
- Primes the processor's line buffers with PRIME_LINES lines, then sends one line per line-buffer-free interrupt (o_intr from image_processor).
- Finishes by injecting PAD_LINES all-zero lines so the last image rows are filtered.
- Sits between the pixel source (DMA/stream) and image_processor's i_data/i_data_valid inputs.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 512, pixels per line
IMG_H, 512, image lines per frame
PRIME_LINES, 4, lines sent back-to-back before the first interrupt is waited for
PAD_LINES, 2, zero lines appended after the last image line

Ports:
axi_clk  in  1  clock
axi_reset  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse: begin a frame; ignored while o_busy=1
s_data  in  DATA_W  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  upstream accept (combinational)
i_proc_ready  in  1  image_processor can accept a pixel (its o_data_ready)
o_data  out  DATA_W  pixel to image_processor i_data (registered)
o_data_valid  out  1  to image_processor i_data_valid (registered)
i_intr  in  1  image_processor o_intr (level; rising edge = one line buffer freed)
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse after the last pad pixel is issued
o_overrun  out  1  sticky: interrupt edge lost because credits were saturated; cleared on accepted i_start

Behaviour:
- Reset: state=IDLE; o_data=0, o_data_valid=0, o_busy=0, o_done=0, o_overrun=0; all counters, credits and the intr edge register cleared. Reset mid-frame aborts immediately, with no further output beats.
- States: IDLE, PRIME, WAIT, LINE, PAD_WAIT, PAD, DONE.
  - IDLE --i_start--> PRIME.
  - PRIME: sends PRIME_LINES*IMG_W pixels -> WAIT. If IMG_H <= PRIME_LINES, it sends IMG_H lines and goes to PAD_WAIT.
  - WAIT --credit>0--> LINE. LINE: sends IMG_W pixels, then -> WAIT, or -> PAD_WAIT after image line IMG_H.
  - PAD_WAIT --credit>0--> PAD. PAD: sends IMG_W zero pixels, then -> PAD_WAIT, or -> DONE after pad line PAD_LINES.
  - DONE: o_done=1 for one cycle -> IDLE.
- Feed states (PRIME, LINE): s_ready = i_proc_ready. A beat occurs when s_valid&&s_ready. The next cycle has o_data_valid=1 and o_data=s_data (1-cycle latency). No beat means o_data_valid=0 next cycle. Bubbles are allowed and the count holds.
- PAD: a beat occurs every cycle with i_proc_ready=1; o_data=0 next cycle; s_ready=0.
- In all other states s_ready=0; o_data_valid follows the beat rule (0 except the cycle after a final beat).
- Counters: pix_cnt is 0..IMG_W-1 and wraps to 0 on the last beat of a line, where line_cnt increments. line_cnt counts image lines then pad lines, total IMG_H+PAD_LINES. Widths use $clog2.
- Credits:
  - intr_q registers i_intr; an edge is i_intr&&!intr_q.
  - credit is a 2-bit counter, +1 per edge, -1 on each WAIT->LINE or PAD_WAIT->PAD transition. A simultaneous edge and consume leaves it unchanged.
  - At credit=3 with an edge and no consume: credit stays 3 and o_overrun is set.
  - Edges are counted in every non-IDLE state, including PRIME and LINE. credit is cleared on the accepted i_start.
- i_start in any non-IDLE state is ignored, with no effect on state or counters.
- The last beat of a line and the state transition occur in the same cycle; the next line's first beat can occur no earlier than the cycle after the state change.

Test Plan:
- IMG_W=8, IMG_H=6, PRIME=4, PAD=2, i_proc_ready=1, s_valid=1, intr pulsed 1 cycle each time 8 beats complete after WAIT entry:
  - 32 beats before the first WAIT; 64 total beats, the last 16 with o_data=0.
  - o_done pulses once, 1 cycle after the last beat; o_busy falls the same cycle.
- Same config, s_valid toggling every cycle: o_data_valid toggles, data order preserved, line boundaries still exactly 8 beats; beat total still 64.
- i_intr edges issued during PRIME (2 edges): WAIT->LINE immediately twice without further intr; credit returns to 0.
- 4 intr edges during PRIME: credit saturates at 3, o_overrun=1 and stays 1 until the next accepted i_start.
- Edge on the same cycle as the WAIT->LINE consume with credit=1: credit stays 1; the following line starts with no new intr.
- axi_reset asserted mid-LINE (pix_cnt=3): the next cycle has o_data_valid=0, o_busy=0, s_ready=0. A new i_start replays a full frame (64 beats).
